// File: rtl/linear_network_multicast_bp.sv
// linear_network_multicast_bp
// Linear chain of single-entry stages carrying packets with a per-packet
// multi-hot destination mask. Each stage offers its packet to the local node
// (valid/ready) and forwards it downstream while later destinations remain.
// A stage frees only after both its local and its forward duties are done.
// Ready is combinational back through the chain, so a stage can refill in
// the same cycle it drains. Zero-mask packets are consumed and counted.

module linear_network_multicast_bp #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_NODE   = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_en,
    input  logic                           i_valid,
    output logic                           i_ready,
    input  logic [DATA_WIDTH-1:0]          i_data_bus,
    input  logic [NUM_NODE-1:0]            i_dest,
    output logic [NUM_NODE-1:0]            o_valid,
    input  logic [NUM_NODE-1:0]            o_ready,
    output logic [NUM_NODE*DATA_WIDTH-1:0] o_data_bus,
    output logic                           o_busy,
    output logic [CNT_WIDTH-1:0]           o_drop_cnt
);

    // Clear every mask bit below position k; stage k only tracks [NUM_NODE-1:k].
    function automatic logic [NUM_NODE-1:0] keep_from(input logic [NUM_NODE-1:0] m,
                                                      input int k);
        logic [NUM_NODE-1:0] r;
        for (int b = 0; b < NUM_NODE; b++) begin
            r[b] = (b >= k) ? m[b] : 1'b0;
        end
        return r;
    endfunction

    // Increment that sticks at all-ones.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // Per-stage state
    logic [NUM_NODE-1:0]   r_v;
    logic [NUM_NODE-1:0]   r_ldone;
    logic [NUM_NODE-1:0]   r_fdone;
    logic [NUM_NODE-1:0]   r_mask [NUM_NODE];
    logic [DATA_WIDTH-1:0] r_data [NUM_NODE];
    logic [CNT_WIDTH-1:0]  r_drop_cnt;

    // Handshake terms
    logic [NUM_NODE-1:0]   w_lpend;
    logic [NUM_NODE-1:0]   w_lfire;
    logic [NUM_NODE-1:0]   w_fpend;
    logic [NUM_NODE-1:0]   w_ffire;
    logic [NUM_NODE-1:0]   w_acc;
    logic                  w_acc_nxt;

    // Stage load sources
    logic [NUM_NODE-1:0]   w_load;
    logic [DATA_WIDTH-1:0] w_ldata [NUM_NODE];
    logic [NUM_NODE-1:0]   w_lmask [NUM_NODE];

    // Input side
    logic                  w_dest_zero;
    logic                  w_hs;
    logic                  w_drop;

    // Local and forward pending terms for every stage.
    always_comb begin
        w_lpend = '0;
        w_lfire = '0;
        w_fpend = '0;
        for (int k = 0; k < NUM_NODE; k++) begin
            w_lpend[k] = r_v[k] & r_mask[k][k] & ~r_ldone[k];
            w_lfire[k] = i_en & w_lpend[k] & o_ready[k];
            if (k < NUM_NODE - 1) begin
                w_fpend[k] = r_v[k] & (|keep_from(r_mask[k], k + 1)) & ~r_fdone[k];
            end
        end
    end

    // Ready ripples from the last stage toward the head: a stage accepts when
    // it is empty or when all its pending duties complete this cycle.
    always_comb begin
        w_acc     = '0;
        w_ffire   = '0;
        w_acc_nxt = 1'b0;
        for (int k = NUM_NODE - 1; k >= 0; k--) begin
            w_ffire[k] = i_en & w_fpend[k] & w_acc_nxt;
            w_acc[k]   = i_en & (~r_v[k] |
                                 ((~w_lpend[k] | w_lfire[k]) & (~w_fpend[k] | w_ffire[k])));
            w_acc_nxt  = w_acc[k];
        end
    end

    // Input handshake: zero-mask packets never need stage 0, so they bypass it.
    always_comb begin
        w_dest_zero = (i_dest == '0);
        i_ready     = ~rst & i_en & (w_dest_zero | w_acc[0]);
        w_hs        = i_valid & i_ready;
        w_drop      = w_hs & w_dest_zero;
    end

    // Stage 0 loads from the input port; stage k loads from stage k-1 on forward.
    for (genvar g = 0; g < NUM_NODE; g++) begin : g_src
        if (g == 0) begin : g_head
            assign w_load[g]  = w_hs & ~w_dest_zero;
            assign w_ldata[g] = i_data_bus;
            assign w_lmask[g] = i_dest;
        end else begin : g_body
            assign w_load[g]  = w_ffire[g-1];
            assign w_ldata[g] = r_data[g-1];
            assign w_lmask[g] = keep_from(r_mask[g-1], g);
        end
    end

    // Stage control: load, free, or record partial completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v     <= '0;
            r_ldone <= '0;
            r_fdone <= '0;
            for (int k = 0; k < NUM_NODE; k++) begin
                r_mask[k] <= '0;
            end
        end else if (i_en) begin
            for (int k = 0; k < NUM_NODE; k++) begin
                if (w_load[k]) begin
                    r_v[k]     <= 1'b1;
                    r_ldone[k] <= 1'b0;
                    r_fdone[k] <= 1'b0;
                    r_mask[k]  <= w_lmask[k];
                end else if (w_acc[k]) begin
                    r_v[k]     <= 1'b0;
                    r_ldone[k] <= 1'b0;
                    r_fdone[k] <= 1'b0;
                end else begin
                    if (w_lfire[k]) r_ldone[k] <= 1'b1;
                    if (w_ffire[k]) r_fdone[k] <= 1'b1;
                end
            end
        end
    end

    // Payload registers; never observed unless the stage is valid, so no reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_NODE; k++) begin
            if (i_en && w_load[k]) begin
                r_data[k] <= w_ldata[k];
            end
        end
    end

    // Saturating count of consumed zero-mask packets.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_drop_cnt <= sat_inc(r_drop_cnt);
        end
    end

    // Local offers; payload slices read zero when not offered.
    always_comb begin
        o_valid    = '0;
        o_data_bus = '0;
        for (int k = 0; k < NUM_NODE; k++) begin
            o_valid[k] = i_en & w_lpend[k];
            o_data_bus[k*DATA_WIDTH +: DATA_WIDTH] = o_valid[k] ? r_data[k] : '0;
        end
    end

    assign o_busy     = |r_v;
    assign o_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_linear_network_multicast_bp.sv
// Bench for linear_network_multicast_bp: per-node expected-packet queues,
// filled on every accepted input and drained on every local handshake,
// checked every cycle, plus directed cycle-exact scenarios.

module tb_linear_network_multicast_bp;
    localparam int DW = 32;
    localparam int NN = 4;
    localparam int CW = 2;
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_en;
    logic              i_valid;
    logic              i_ready;
    logic [DW-1:0]     i_data_bus;
    logic [NN-1:0]     i_dest;
    logic [NN-1:0]     o_valid;
    logic [NN-1:0]     o_ready;
    logic [NN*DW-1:0]  o_data_bus;
    logic              o_busy;
    logic [CW-1:0]     o_drop_cnt;

    int n_vec = 0;
    int n_bad = 0;

    logic [DW-1:0] q [NN][$];
    logic [CW-1:0] drop_m = '0;

    linear_network_multicast_bp #(
        .DATA_WIDTH(DW), .NUM_NODE(NN), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .i_en(i_en), .i_valid(i_valid), .i_ready(i_ready),
        .i_data_bus(i_data_bus), .i_dest(i_dest), .o_valid(o_valid),
        .o_ready(o_ready), .o_data_bus(o_data_bus), .o_busy(o_busy),
        .o_drop_cnt(o_drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] slice(input int k);
        return o_data_bus[k*DW +: DW];
    endfunction

    // Reference model: every node consumes its packets in acceptance order.
    always @(negedge clk) begin
        int pend;
        logic [DW-1:0] sl;
        pend = 0;
        for (int k = 0; k < NN; k++) pend += q[k].size();
        chk("busy", o_busy, pend != 0);
        chk("drop_cnt", o_drop_cnt, drop_m);
        if (rst || !i_en) chk("ready_off", i_ready, 0);
        else if (pend == 0 || (i_valid && i_dest == '0)) chk("ready_on", i_ready, 1);
        for (int k = 0; k < NN; k++) begin
            sl = slice(k);
            if (!i_en) chk($sformatf("valid_gated%0d", k), o_valid[k], 0);
            if (o_valid[k]) begin
                if (q[k].size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL offer_node%0d: got packet %0h, expected no offer at %0t",
                             k, sl, $time);
                end else begin
                    chk($sformatf("offer_data%0d", k), sl, q[k][0]);
                    if (o_ready[k] && !rst) void'(q[k].pop_front());
                end
            end else begin
                chk($sformatf("idle_data%0d", k), sl, 0);
            end
        end
        if (i_valid && i_ready && !rst) begin
            if (i_dest == '0) begin
                if (drop_m != CNT_MAX) drop_m = drop_m + 1'b1;
            end else begin
                for (int k = 0; k < NN; k++) if (i_dest[k]) q[k].push_back(i_data_bus);
            end
        end
        if (rst) begin
            for (int k = 0; k < NN; k++) q[k].delete();
            drop_m = '0;
        end
    end

    initial begin
        int total;
        rst = 1'b1; i_en = 1'b1; i_valid = 1'b0; i_data_bus = '0; i_dest = '0; o_ready = '1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", o_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_cnt", o_drop_cnt, 0);
        chk("rst_data", o_data_bus, 0);

        // Zero-mask drops with a 2-bit counter
        cyc(); i_valid = 1'b1; i_dest = '0; i_data_bus = 32'h12345678;
        @(negedge clk); chk("drop_ready", i_ready, 1);
        for (int i = 1; i <= 5; i++) begin
            cyc(); if (i == 5) i_valid = 1'b0;
            @(negedge clk);
            chk("drop_cnt_lit", o_drop_cnt, (i > 3) ? 3 : i);
            chk("drop_no_valid", o_valid, 0);
            if (i < 5) chk("drop_ready", i_ready, 1);
        end

        // Single local delivery at node 0
        cyc(); i_valid = 1'b1; i_dest = 4'b0001; i_data_bus = 32'hAAAAAAAA;
        @(negedge clk); chk("t1_ready", i_ready, 1);
        cyc(); i_valid = 1'b0;
        @(negedge clk);
        chk("t1_valid", o_valid, 4'b0001);
        chk("t1_slice0", slice(0), 32'hAAAAAAAA);
        chk("t1_busy", o_busy, 1);
        cyc(); @(negedge clk);
        chk("t1_valid_after", o_valid, 0);
        chk("t1_busy_after", o_busy, 0);

        // Back-to-back broadcasts
        cyc(); i_valid = 1'b1; i_dest = 4'hF; i_data_bus = 32'hAAAAAAAA;
        cyc(); i_data_bus = 32'hBBBBBBBB;
        @(negedge clk);
        chk("t2_c1_valid", o_valid, 4'b0001); chk("t2_c1_s0", slice(0), 32'hAAAAAAAA);
        chk("t2_c1_ready", i_ready, 1);
        cyc(); i_valid = 1'b0;
        @(negedge clk);
        chk("t2_c2_valid", o_valid, 4'b0011);
        chk("t2_c2_s0", slice(0), 32'hBBBBBBBB); chk("t2_c2_s1", slice(1), 32'hAAAAAAAA);
        cyc(); @(negedge clk);
        chk("t2_c3_valid", o_valid, 4'b0110);
        chk("t2_c3_s1", slice(1), 32'hBBBBBBBB); chk("t2_c3_s2", slice(2), 32'hAAAAAAAA);
        cyc(); @(negedge clk);
        chk("t2_c4_valid", o_valid, 4'b1100); chk("t2_c4_s3", slice(3), 32'hAAAAAAAA);
        cyc(); @(negedge clk);
        chk("t2_c5_valid", o_valid, 4'b1000); chk("t2_c5_s3", slice(3), 32'hBBBBBBBB);
        cyc(); @(negedge clk);
        chk("t2_busy_after", o_busy, 0);

        // Backpressure on node 1 under a broadcast stream
        cyc(); o_ready = 4'b1101; i_valid = 1'b1; i_dest = 4'hF; i_data_bus = $urandom;
        cyc(); i_data_bus = $urandom;
        cyc(); i_data_bus = $urandom;
        @(negedge clk); chk("t3_ready_drop", i_ready, 0);
        cyc(); i_data_bus = $urandom;
        cyc(); o_ready = '1;
        repeat (6) begin cyc(); i_data_bus = $urandom; end
        cyc(); i_valid = 1'b0;
        repeat (12) cyc();
        @(negedge clk); chk("t3_drained", o_busy, 0);

        // Partial delivery: node 3 stalled while a newer packet completes
        cyc(); o_ready = 4'b0111; i_valid = 1'b1; i_dest = 4'b1010; i_data_bus = 32'hC0C0C0C0;
        @(negedge clk); chk("t4_c0_valid", o_valid, 0);
        cyc(); i_valid = 1'b0;
        @(negedge clk); chk("t4_c1_valid", o_valid, 0);
        cyc(); @(negedge clk);
        chk("t4_c2_valid", o_valid, 4'b0010); chk("t4_c2_s1", slice(1), 32'hC0C0C0C0);
        cyc(); @(negedge clk); chk("t4_c3_valid", o_valid, 0);
        cyc(); i_valid = 1'b1; i_dest = 4'b0011; i_data_bus = 32'hD1D1D1D1;
        @(negedge clk);
        chk("t4_c4_valid", o_valid, 4'b1000); chk("t4_c4_s3", slice(3), 32'hC0C0C0C0);
        chk("t4_c4_ready", i_ready, 1);
        cyc(); i_valid = 1'b0;
        @(negedge clk);
        chk("t4_c5_valid", o_valid, 4'b1001); chk("t4_c5_s0", slice(0), 32'hD1D1D1D1);
        cyc(); @(negedge clk);
        chk("t4_c6_valid", o_valid, 4'b1010); chk("t4_c6_s1", slice(1), 32'hD1D1D1D1);
        cyc(); @(negedge clk); chk("t4_c7_valid", o_valid, 4'b1000);
        cyc(); o_ready = '1;
        cyc(); @(negedge clk);
        chk("t4_c9_valid", o_valid, 0); chk("t4_c9_busy", o_busy, 0);

        // Freeze with packets at stages 0 and 2
        cyc(); i_valid = 1'b1; i_dest = 4'hF; i_data_bus = 32'h11110000;
        cyc(); i_valid = 1'b0;
        cyc(); i_valid = 1'b1; i_data_bus = 32'h22220000;
        cyc(); i_en = 1'b0; i_dest = '0;
        @(negedge clk); chk("en_valid", o_valid, 0); chk("en_ready", i_ready, 0);
        repeat (2) begin cyc(); @(negedge clk); chk("en_valid", o_valid, 0); end
        cyc(); i_en = 1'b1; i_valid = 1'b0;
        @(negedge clk);
        chk("en_resume_valid", o_valid, 4'b0101);
        chk("en_resume_s0", slice(0), 32'h22220000); chk("en_resume_s2", slice(2), 32'h11110000);
        cyc(); @(negedge clk);
        chk("en_next_valid", o_valid, 4'b1010);
        chk("en_next_s1", slice(1), 32'h22220000); chk("en_next_s3", slice(3), 32'h11110000);
        repeat (3) cyc();

        // Reset mid-flight
        cyc(); o_ready = 4'b0101; i_valid = 1'b1; i_dest = 4'hF; i_data_bus = $urandom;
        repeat (3) begin cyc(); i_data_bus = $urandom; end
        @(negedge clk); chk("pre_rst_busy", o_busy, 1);
        cyc(); rst = 1'b1;
        @(negedge clk); chk("rst_ready_lit", i_ready, 0);
        cyc(); rst = 1'b0; i_valid = 1'b0; o_ready = '1;
        @(negedge clk);
        chk("mid_rst_busy", o_busy, 0); chk("mid_rst_valid", o_valid, 0);
        chk("mid_rst_cnt", o_drop_cnt, 0);

        // Randomised traffic
        for (int c = 0; c < 1500; c++) begin
            cyc();
            rst        = ($urandom_range(0, 299) == 0);
            i_en       = ($urandom_range(0, 15) != 0);
            i_valid    = ($urandom_range(0, 2) != 0);
            i_dest     = ($urandom_range(0, 7) == 0) ? '0 : NN'($urandom);
            i_data_bus = $urandom;
            o_ready    = NN'($urandom) | NN'($urandom);
        end
        cyc(); rst = 1'b0; i_en = 1'b1; i_valid = 1'b0; o_ready = '1;
        repeat (NN + 6) cyc();
        @(negedge clk);
        total = 0;
        for (int k = 0; k < NN; k++) total += q[k].size();
        chk("final_pending", total, 0);
        chk("final_busy", o_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/linear_network_multicast_bp.md
# linear_network_multicast_bp

Parametrised linear multicast chain with per-packet destination masks and per-node valid/ready backpressure. One packet enters per cycle at the head of a chain of NUM_NODE single-entry register stages. Each stage delivers to its local node when that node's mask bit is set, and forwards downstream while any later mask bit remains set. It sits between a buffer/scratchpad read port and a row of PEs, replacing the static-command multicast chain wherever destinations change packet by packet or consumers can stall.

## Interface
- DATA_WIDTH, 32, payload width
- NUM_NODE, 4, number of stages/local outputs (>=1)
- CNT_WIDTH, 16, width of drop counter
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- i_en  in  1  global enable; 0 freezes all state
- i_valid  in  1  input packet valid
- i_ready  out  1  input accepted when i_valid & i_ready
- i_data_bus  in  DATA_WIDTH  input payload
- i_dest  in  NUM_NODE  multi-hot destination mask; bit k = node k
- o_valid  out  NUM_NODE  bit k: local packet offered to node k
- o_ready  in  NUM_NODE  bit k: node k accepts
- o_data_bus  out  NUM_NODE*DATA_WIDTH  slice [k*DATA_WIDTH+:DATA_WIDTH] = node k payload
- o_busy  out  1  OR of all stage valid flags
- o_drop_cnt  out  CNT_WIDTH  saturating count of zero-mask packets consumed

## Operation
- Stage k state: v_k, data_k, mask_k[NUM_NODE-1:k], ldone_k, fdone_k.
- lpend_k = v_k & mask_k[k] & ~ldone_k; o_valid[k] = i_en & lpend_k; lfire_k = o_valid[k] & o_ready[k].
- fpend_k = v_k & |mask_k[NUM_NODE-1:k+1] & ~fdone_k. Last stage: fpend = 0. ffire_k = i_en & fpend_k & acc_{k+1}.
- Stage k empties when (~lpend_k | lfire_k) & (~fpend_k | ffire_k), or when ~v_k. acc_k = i_en & that empty condition, so a stage can be refilled in the cycle it drains.
- Partial completion: lfire without ffire sets ldone_k, and ffire without lfire sets fdone_k. The packet stays in the stage until both are done. Local and forward never repeat.
- Load into stage k+1 on ffire_k: data, mask bits [NUM_NODE-1:k+1], ldone=fdone=0, v=1.
- Input: i_ready = ~rst & i_en & (i_dest==0 | acc_0). A handshake with i_dest!=0 loads stage 0. A handshake with i_dest==0 is consumed and not stored; o_drop_cnt increments, saturating at all-ones.
- o_data_bus slice k = data_k when o_valid[k], else 0.
- i_en=0: no register changes, o_valid=0, i_ready=0, drop counter holds.
- Per node, packets arrive in input order. There is no reordering and no loss.
- The ready path is combinational from o_ready[NUM_NODE-1] back to i_ready, depth NUM_NODE. This is accepted for NUM_NODE<=16.

## Timing
- Reset (cycle after rst high at edge): all v_k=0, o_valid=0, o_data_bus=0, o_busy=0, o_drop_cnt=0, i_ready=0 while rst=1.
- Reset mid-flight discards all in-flight packets. There are no partial deliveries after the reset edge.
- Latency: accepted at edge t, the packet is offered at node k from cycle t+1+k when there are no stalls.
- Throughput: 1 packet/cycle sustained with all o_ready=1.
- When stage 0 is empty, it accepts regardless of downstream state.
- Simultaneous fire: lfire_k and ffire_k in the same cycle empty the stage in one cycle.
- A drop and a stage-0 load never coincide, because one handshake carries one packet.

## Test plan
- Reset, then i_dest=4'b0001, data=32'hAAAAAAAA, o_ready=4'hF -> o_valid=4'b0001 for one cycle at t+1, slice 0=AAAAAAAA. Stage 1 is never valid. o_busy returns to 0 at t+2.
- Broadcast i_dest=4'hF, data=AAAAAAAA then BBBBBBBB on consecutive cycles -> o_valid[k] at t+1+k for A and t+2+k for B. Each slice shows correct data; i_ready stays 1.
- Backpressure: stream broadcasts, hold o_ready[1]=0 for 4 cycles -> stage 1 holds one packet, stage 0 sets ldone and then stalls. i_ready drops to 0 within 2 cycles. After release, all packets reach every node in order with none duplicated.
- Partial delivery: i_dest=4'b1010, o_ready[3]=0 for 5 cycles -> node 1 receives at t+2. The packet sits at stage 3 while a new packet with i_dest=4'b0011 completes at nodes 0 and 1 unaffected.
- Drop: CNT_WIDTH=2, five packets with i_dest=0 -> each is accepted immediately, no o_valid, o_drop_cnt=1,2,3,3,3.
- i_en=0 for 3 cycles with packets at stages 0 and 2 -> all state frozen, o_valid=0, and the packets resume unchanged on i_en=1. rst=1 mid-flight -> o_busy=0 and o_valid=0 next cycle.
